// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants, types and helpers for the register file with pending-write scoreboard.
package regfile_scoreboard_pkg;

  localparam int unsigned DEF_N        = 32;
  localparam int unsigned DEF_NUM_REGS = 32;
  localparam int unsigned DEF_PEND_W   = 2;
  localparam int unsigned X0           = 0;

  typedef logic [DEF_PEND_W-1:0] pend_t;

  // Address width for a register count; never narrower than one bit.
  function automatic int unsigned addr_w(input int unsigned regs);
    return (regs > 2) ? $clog2(regs) : 1;
  endfunction

endpackage

// File: rtl/regfile_pend_ctr.sv
// Per-register saturating up/down pending-write counter with max/zero detect.
module regfile_pend_ctr #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         max_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign cnt_o  = cnt_q;
  assign max_o  = (cnt_q == '1);
  assign zero_o = (cnt_q == '0);

  // Simultaneous inc and dec cancel: the newer producer keeps the register busy.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && !max_o)
      cnt_d = cnt_q + W'(1);
    else if (dec_i && !inc_i && !zero_o)
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// 2R/1W register file (x0 hardwired to zero) with per-register pending-write scoreboard.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter  int unsigned N        = DEF_N,
  parameter  int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter  int unsigned PEND_W   = DEF_PEND_W,
  localparam int unsigned ADDR_W   = addr_w(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ReadAddress1,
  input  logic [ADDR_W-1:0] ReadAddress2,
  output logic [N-1:0]      ReadData1,
  output logic [N-1:0]      ReadData2,
  output logic              ReadBusy1,
  output logic              ReadBusy2,
  input  logic              Reserve,
  input  logic [ADDR_W-1:0] ReserveAddress,
  output logic              ReserveReady,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteAddress,
  input  logic [N-1:0]      WriteData,
  output logic              Underflow
);

  localparam logic [ADDR_W-1:0] X0A = ADDR_W'(X0);

  logic [N-1:0]        regs_q [NUM_REGS];
  logic [PEND_W-1:0]   cnt    [NUM_REGS];
  logic [NUM_REGS-1:0] max_v, zero_v, inc_v, dec_v;
  logic                res_acc, wr_en, underflow_q;

  assign wr_en        = RegWrite && (WriteAddress != X0A);
  assign ReserveReady = (ReserveAddress == X0A) || !max_v[ReserveAddress] ||
                        (RegWrite && (WriteAddress == ReserveAddress));
  assign res_acc      = Reserve && ReserveReady && (ReserveAddress != X0A);
  assign Underflow    = underflow_q;

  assign cnt[0]    = '0;
  assign max_v[0]  = 1'b0;
  assign zero_v[0] = 1'b1;
  assign inc_v[0]  = 1'b0;
  assign dec_v[0]  = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_ctr
    assign inc_v[r] = res_acc && (ReserveAddress == ADDR_W'(r));
    assign dec_v[r] = wr_en && (WriteAddress == ADDR_W'(r)) && !zero_v[r];

    regfile_pend_ctr #(.W(PEND_W)) u_ctr (
      .clk    (clk),
      .rst    (rst),
      .inc_i  (inc_v[r]),
      .dec_i  (dec_v[r]),
      .cnt_o  (cnt[r]),
      .max_o  (max_v[r]),
      .zero_o (zero_v[r])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_en) regs_q[WriteAddress] <= WriteData;
      // A same-edge reservation of the target turns the write into a fresh producer, not an error.
      if (wr_en && zero_v[WriteAddress] &&
          !(res_acc && (ReserveAddress == WriteAddress)))
        underflow_q <= 1'b1;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic [NUM_REGS-1:0] post_busy;
  assign post_busy[0] = 1'b0;
  for (genvar r = 1; r < NUM_REGS; r++) begin : g_post
    assign post_busy[r] = inc_v[r] ||
                          (!zero_v[r] && !(dec_v[r] && (cnt[r] == PEND_W'(1))));
  end
`endif

  always_comb begin
    ReadData1 = '0;
    ReadBusy1 = 1'b0;
    if (ReadAddress1 != X0A) begin
      ReadData1 = regs_q[ReadAddress1];
      ReadBusy1 = !zero_v[ReadAddress1];
`ifdef REGFILE_BYPASS_EN
      if (RegWrite && (WriteAddress == ReadAddress1)) begin
        ReadData1 = WriteData;
        ReadBusy1 = post_busy[ReadAddress1];
      end
`endif
    end
  end

  always_comb begin
    ReadData2 = '0;
    ReadBusy2 = 1'b0;
    if (ReadAddress2 != X0A) begin
      ReadData2 = regs_q[ReadAddress2];
      ReadBusy2 = !zero_v[ReadAddress2];
`ifdef REGFILE_BYPASS_EN
      if (RegWrite && (WriteAddress == ReadAddress2)) begin
        ReadData2 = WriteData;
        ReadBusy2 = post_busy[ReadAddress2];
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: directed scenarios plus randomized traffic.
module tb_regfile_scoreboard;

  localparam int NR   = 32;
  localparam int AW   = 5;
  localparam int PMAX = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] ReadAddress1, ReadAddress2, ReserveAddress, WriteAddress;
  logic [31:0]   ReadData1, ReadData2, WriteData;
  logic          ReadBusy1, ReadBusy2, Reserve, ReserveReady, RegWrite, Underflow;

  regfile_scoreboard #(.N(32), .NUM_REGS(32), .PEND_W(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .ReadAddress1   (ReadAddress1),
    .ReadAddress2   (ReadAddress2),
    .ReadData1      (ReadData1),
    .ReadData2      (ReadData2),
    .ReadBusy1      (ReadBusy1),
    .ReadBusy2      (ReadBusy2),
    .Reserve        (Reserve),
    .ReserveAddress (ReserveAddress),
    .ReserveReady   (ReserveReady),
    .RegWrite       (RegWrite),
    .WriteAddress   (WriteAddress),
    .WriteData      (WriteData),
    .Underflow      (Underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d1, d2;
    logic        b1, b2, rr, uf;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: plain arrays of values and in-flight write counts.
  logic [31:0] m_regs [NR];
  int          m_pend [NR];
  bit          m_uf;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("ReadData1",    ReadData1,    e.d1);
      chk("ReadData2",    ReadData2,    e.d2);
      chk("ReadBusy1",    32'(ReadBusy1),    32'(e.b1));
      chk("ReadBusy2",    32'(ReadBusy2),    32'(e.b2));
      chk("ReserveReady", 32'(ReserveReady), 32'(e.rr));
      chk("Underflow",    32'(Underflow),    32'(e.uf));
    end
  end

  task automatic cyc(input bit r, input bit res, input int rsa, input bit we,
                     input int wa, input logic [31:0] wd, input int a1, input int a2);
    exp_t e;
    int   post [NR];
    bit   rr, acc, wr;
    rst            = r;
    Reserve        = res;
    ReserveAddress = AW'(rsa);
    RegWrite       = we;
    WriteAddress   = AW'(wa);
    WriteData      = wd;
    ReadAddress1   = AW'(a1);
    ReadAddress2   = AW'(a2);

    rr  = (rsa == 0) || (m_pend[rsa] < PMAX) || (we && wa == rsa);
    acc = res && rr && (rsa != 0);
    wr  = we && (wa != 0);
    post = m_pend;
    if (acc) post[rsa] = post[rsa] + 1;
    if (wr && m_pend[wa] > 0) post[wa] = post[wa] - 1;

    e.rr = rr;
    e.uf = m_uf;
    e.d1 = (a1 == 0) ? 32'h0 : m_regs[a1];
    e.b1 = (a1 != 0) && (m_pend[a1] > 0);
    e.d2 = (a2 == 0) ? 32'h0 : m_regs[a2];
    e.b2 = (a2 != 0) && (m_pend[a2] > 0);
`ifdef REGFILE_BYPASS_EN
    if (wr && wa == a1) begin e.d1 = wd; e.b1 = (post[a1] > 0); end
    if (wr && wa == a2) begin e.d2 = wd; e.b2 = (post[a2] > 0); end
`endif
    q.push_back(e);

    if (r) begin
      for (int i = 0; i < NR; i++) begin m_regs[i] = '0; m_pend[i] = 0; end
      m_uf = 1'b0;
    end else begin
      if (wr && m_pend[wa] == 0 && !(acc && rsa == wa)) m_uf = 1'b1;
      if (wr) m_regs[wa] = wd;
      m_pend = post;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int a1, input int a2);
    cyc(0, 0, 0, 0, 0, 32'h0, a1, a2);
  endtask

  initial begin
    rst = 1'b1; Reserve = 0; ReserveAddress = '0; RegWrite = 0; WriteAddress = '0;
    WriteData = '0; ReadAddress1 = '0; ReadAddress2 = '0;
    for (int i = 0; i < NR; i++) begin m_regs[i] = '0; m_pend[i] = 0; end
    m_uf = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Random writes, then a reset that also ignores a concurrent write/reserve.
    for (int i = 0; i < 6; i++) cyc(0, 1, i + 1, 1, i + 2, $urandom, i + 2, i + 1);
    cyc(1, 1, 6, 1, 6, 32'hCAFE0000, 3, 6);
    idle(3, 6);
    idle(2, 7);

    // Reserve x5, writeback two cycles later.
    cyc(0, 1, 5, 0, 0, 32'h0, 5, 0);
    idle(5, 5);
    cyc(0, 0, 0, 1, 5, 32'hDEADBEEF, 5, 0);
    idle(5, 0);

    // Saturate x7, then a writeback-enabled reservation at max.
    repeat (3) cyc(0, 1, 7, 0, 0, 32'h0, 7, 0);
    cyc(0, 1, 7, 0, 0, 32'h0, 7, 0);
    cyc(0, 1, 7, 1, 7, 32'h77, 7, 0);
    repeat (3) cyc(0, 0, 0, 1, 7, 32'h70, 7, 7);
    idle(7, 0);

    // Reserve and writeback of x3 on the same edge with one pending.
    cyc(0, 1, 3, 0, 0, 32'h0, 3, 0);
    cyc(0, 1, 3, 1, 3, 32'h33, 3, 0);
    idle(3, 0);

    // Unreserved writeback sets sticky Underflow; x0 write has no effect.
    cyc(0, 0, 0, 1, 9, 32'h1234, 9, 0);
    idle(9, 0);
    cyc(0, 0, 0, 1, 0, 32'hFFFF, 0, 9);
    idle(0, 9);
    cyc(0, 1, 0, 0, 0, 32'h0, 0, 9);
    cyc(1, 0, 0, 0, 0, 32'h0, 9, 0);
    idle(9, 0);

    // Same-cycle read of the register being written back.
    cyc(0, 1, 4, 0, 0, 32'h0, 4, 0);
    cyc(0, 0, 0, 1, 4, 32'h11, 4, 0);
    cyc(0, 1, 4, 0, 0, 32'h0, 4, 0);
    cyc(0, 0, 0, 1, 4, 32'hA5A5A5A5, 4, 4);
    idle(4, 0);

    // Randomized traffic on a narrow address window to reach saturation often.
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(0, 199) == 0), $urandom_range(0, 1), $urandom_range(0, 7),
          $urandom_range(0, 1), $urandom_range(0, 7), $urandom,
          $urandom_range(0, 7), $urandom_range(0, NR - 1));
    end

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
